magnetron_sequencer: RTL

Clocked successor to the combinational magnetron enable. Adds a loaded cook time, a once-per-second countdown, power-level duty cycling, and pause/resume with a door interlock. Sits between the keypad/front-panel decoder and the magnetron driver. Drives `enabler`, the single safety-critical output, and reports remaining time to the display.

---
 rtl/magnetron_pkg.sv | 24 ++
 rtl/magnetron_tick_gen.sv | 34 +++
 rtl/magnetron_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/magnetron_pkg.sv
// Shared types and helpers for the magnetron sequencer: state encoding,
// quick-add seconds and power-level clamping.
package magnetron_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } mag_state_t;

  localparam int ADD_SECS = 30;

  // A request of 0 means "no preference", so it runs at full power like an over-range value.
  function automatic int unsigned clamp_power(input int unsigned req, input int unsigned levels);
    if ((req == 32'd0) || (req > levels)) begin
      return levels;
    end else begin
      return req;
    end
  endfunction

endpackage

// File: rtl/magnetron_tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1 while enabled and pulses o_tick
// during the terminal count; i_zero restarts the second.
module magnetron_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_zero,
  output logic o_tick
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = (r_cnt == CNT_W'(TICK_DIV - 1));
  assign o_tick   = i_en & w_at_max;

  // Prescaler; holds its partial count while disabled so a pause does not lose time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_zero) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_max ? '0 : (r_cnt + CNT_W'(1));
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/magnetron_sequencer.sv
// Cook-cycle sequencer driving the magnetron enable: load, countdown, duty cycling,
// pause/resume and door interlock. Optional feature macro: MAGNETRON_SEQ_ADD30_EN.
module magnetron_sequencer
  import magnetron_pkg::*;
#(
  parameter int TIME_W     = 12,
  parameter int TICK_DIV   = 50_000_000,
  parameter int PWR_LEVELS = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            stop,
  input  logic                            clear,
  input  logic                            door_closed,
  input  logic                            load,
  input  logic [TIME_W-1:0]               load_time,
  input  logic [$clog2(PWR_LEVELS+1)-1:0] power_level,
  output logic                            enabler,
  output logic                            running,
  output logic                            paused,
  output logic                            done,
  output logic [TIME_W-1:0]               time_left
);

  localparam int PW = $clog2(PWR_LEVELS + 1);

  mag_state_t        r_state;
  mag_state_t        w_state_nx;
  logic [TIME_W-1:0] r_time;
  logic [TIME_W-1:0] w_time_nx;
  logic [TIME_W-1:0] w_time_dec;
  logic [PW-1:0]     r_power;
  logic [PW-1:0]     w_power_nx;
  logic [PW-1:0]     r_phase;
  logic [PW-1:0]     w_phase_nx;
  logic [PW-1:0]     w_phase_inc;
  logic              w_tick_en;
  logic              w_tick;
  logic              w_presc_zero;

  // Counting stops in any cycle where a higher-priority pause or cancel is pending.
  assign w_tick_en    = (r_state == ST_COOK) & ~clear & ~stop & door_closed;
  assign w_presc_zero = (w_state_nx == ST_IDLE);

  magnetron_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_tick_en),
    .i_zero (w_presc_zero),
    .o_tick (w_tick)
  );

  assign w_phase_inc = (r_phase == PW'(PWR_LEVELS - 1)) ? '0 : (r_phase + PW'(1));
  assign w_time_dec  = (w_tick && (r_time != '0)) ? (r_time - TIME_W'(1)) : r_time;

`ifdef MAGNETRON_SEQ_ADD30_EN
  logic [TIME_W:0]   w_sum;
  logic [TIME_W-1:0] w_time_add;

  assign w_sum      = {1'b0, w_time_dec} + (TIME_W + 1)'(ADD_SECS);
  assign w_time_add = w_sum[TIME_W] ? '1 : w_sum[TIME_W-1:0];
`endif

  // Next-state, time, power and phase selection in priority order.
  always_comb begin
    w_state_nx = r_state;
    w_time_nx  = r_time;
    w_power_nx = r_power;
    w_phase_nx = r_phase;
    case (r_state)
      ST_IDLE: begin
        if (clear) begin
          w_time_nx = '0;
`ifdef MAGNETRON_SEQ_ADD30_EN
        end else if (start && door_closed) begin
          w_state_nx = ST_COOK;
          w_time_nx  = TIME_W'(ADD_SECS);
          w_power_nx = PW'(PWR_LEVELS);
          w_phase_nx = '0;
`endif
        end else if (load && (load_time != '0)) begin
          w_state_nx = ST_ARMED;
          w_time_nx  = load_time;
          w_power_nx = PW'(clamp_power(32'(power_level), 32'(PWR_LEVELS)));
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (clear) begin
          w_state_nx = ST_IDLE;
          w_time_nx  = '0;
        end else if (start && door_closed) begin
          w_state_nx = ST_COOK;
        end else begin
          w_state_nx = ST_ARMED;
        end
      end
      ST_COOK: begin
        if (clear) begin
          w_state_nx = ST_IDLE;
          w_time_nx  = '0;
          w_phase_nx = '0;
        end else if (stop || !door_closed) begin
          w_state_nx = ST_PAUSE;
        end else begin
          if (w_tick) begin
            w_phase_nx = w_phase_inc;
          end else begin
            w_phase_nx = r_phase;
          end
          if (w_tick && (r_time <= TIME_W'(1))) begin
            w_state_nx = ST_DONE;
            w_time_nx  = '0;
`ifdef MAGNETRON_SEQ_ADD30_EN
          end else if (start) begin
            w_time_nx = w_time_add;
`endif
          end else begin
            w_time_nx = w_time_dec;
          end
        end
      end
      ST_PAUSE: begin
        if (clear || stop) begin
          w_state_nx = ST_IDLE;
          w_time_nx  = '0;
          w_phase_nx = '0;
        end else if (start && door_closed) begin
          w_state_nx = ST_COOK;
        end else begin
          w_state_nx = ST_PAUSE;
        end
      end
      ST_DONE: begin
        w_time_nx = '0;
        if (clear || !door_closed) begin
          w_state_nx = ST_IDLE;
          w_phase_nx = '0;
        end else begin
          w_state_nx = ST_DONE;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_time_nx  = '0;
        w_phase_nx = '0;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_time  <= '0;
      r_power <= PW'(PWR_LEVELS);
      r_phase <= '0;
    end else begin
      r_state <= w_state_nx;
      r_time  <= w_time_nx;
      r_power <= w_power_nx;
      r_phase <= w_phase_nx;
    end
  end

  // The door term is deliberately combinational so an opening door cuts power without waiting for a clock.
  assign enabler   = (r_state == ST_COOK) & (r_phase < r_power) & door_closed;
  assign running   = (r_state == ST_COOK);
  assign paused    = (r_state == ST_PAUSE);
  assign done      = (r_state == ST_DONE);
  assign time_left = r_time;

endmodule
